axis_test: RTL and testbench

//  Store-and-forward loopback for AXI-Stream metadata beats (data/keep/tid/tdt/sop/eop).

---
 rtl/axis_test_pkg.sv | 21 ++
 rtl/axis_meta_fifo.sv | 68 ++++++
 rtl/axis_test.sv | 83 ++++++++
 tb/tb_axis_test.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_test_pkg.sv
// Shared widths and the packed beat layout for the AXIS metadata loopback.
package axis_test_pkg;

    localparam int META_DATA_W = 128;
    localparam int META_KEEP_W = META_DATA_W / 8;
    localparam int META_TID_W  = 4;
    localparam int META_TDT_W  = 4;
    localparam int META_DEPTH  = 16;

    typedef struct packed {
        logic [META_DATA_W-1:0] data;
        logic [META_KEEP_W-1:0] keep;
        logic [META_TID_W-1:0]  tid;
        logic [META_TDT_W-1:0]  tdt;
        logic                   sop;
        logic                   eop;
    } meta_beat_t;

    localparam int META_W = $bits(meta_beat_t);

endpackage

// File: rtl/axis_meta_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Latency: an entry pushed at edge t is visible on o_head_dat after edge t.
// Backpressure: pushes refused while full (even with a same-cycle pop); pops ignored while empty.
module axis_meta_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push_vld,
    input  logic [WIDTH-1:0]             i_push_dat,
    input  logic                         i_pop_vld,
    output logic [WIDTH-1:0]             o_head_dat,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    // Full/empty come from the registered count only, so ready never depends on pop.
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push_vld && !o_full;
    assign w_pop   = i_pop_vld && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= CW'(DEPTH));

endmodule

// File: rtl/axis_test.sv
// Store-and-forward loopback of AXIS metadata beats through a small FIFO, fields bit-exact.
// Latency: 1 cycle from rx accept to tx valid; 1 beat/clk when tx_meta_rdy is high.
// Backpressure: rx_meta_rdy drops only when the FIFO is full; tx holds its head stable while stalled.
module axis_test
    import axis_test_pkg::*;
#(
    parameter int DEPTH = META_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [META_DATA_W-1:0] rx_meta_data,
    input  logic [META_KEEP_W-1:0] rx_meta_keep,
    input  logic                   rx_meta_vld,
    input  logic [META_TID_W-1:0]  rx_meta_tid,
    input  logic [META_TDT_W-1:0]  rx_meta_tdt,
    input  logic                   rx_meta_sop,
    input  logic                   rx_meta_eop,
    output logic                   rx_meta_rdy,
    output logic [META_DATA_W-1:0] tx_meta_data,
    output logic [META_KEEP_W-1:0] tx_meta_keep,
    output logic                   tx_meta_vld,
    output logic [META_TID_W-1:0]  tx_meta_tid,
    output logic [META_TDT_W-1:0]  tx_meta_tdt,
    output logic                   tx_meta_sop,
    output logic                   tx_meta_eop,
    input  logic                   tx_meta_rdy
);

    localparam int CW = $clog2(DEPTH+1);

    meta_beat_t    w_rx_beat;
    meta_beat_t    w_tx_beat;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_push;
    logic          w_pop;

    always_comb begin
        w_rx_beat      = '0;
        w_rx_beat.data = rx_meta_data;
        w_rx_beat.keep = rx_meta_keep;
        w_rx_beat.tid  = rx_meta_tid;
        w_rx_beat.tdt  = rx_meta_tdt;
        w_rx_beat.sop  = rx_meta_sop;
        w_rx_beat.eop  = rx_meta_eop;
    end

    assign rx_meta_rdy = !w_full;
    assign tx_meta_vld = !w_empty;
    assign w_push      = rx_meta_vld && rx_meta_rdy;
    assign w_pop       = tx_meta_vld && tx_meta_rdy;

    axis_meta_fifo #(
        .WIDTH (META_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push_vld (w_push),
        .i_push_dat (w_rx_beat),
        .i_pop_vld  (w_pop),
        .o_head_dat (w_tx_beat),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    assign tx_meta_data = w_tx_beat.data;
    assign tx_meta_keep = w_tx_beat.keep;
    assign tx_meta_tid  = w_tx_beat.tid;
    assign tx_meta_tdt  = w_tx_beat.tdt;
    assign tx_meta_sop  = w_tx_beat.sop;
    assign tx_meta_eop  = w_tx_beat.eop;

    // A stalled head beat must neither vanish nor change until it is taken.
    a_tx_stable: assert property (@(posedge clk) disable iff (!rst_n)
        tx_meta_vld && !tx_meta_rdy |=> tx_meta_vld && $stable(w_tx_beat));

    a_flags: assert property (@(posedge clk) disable iff (!rst_n)
        (w_count == '0) == w_empty && (w_count == CW'(DEPTH)) == w_full);

endmodule

// File: tb/tb_axis_test.sv
// Directed and random loopback bench for axis_test with a beat scoreboard and stall monitor.
module tb_axis_test;
    import axis_test_pkg::*;

    localparam int BW = META_W;
    typedef logic [159:0] chk_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [META_DATA_W-1:0] rx_meta_data;
    logic [META_KEEP_W-1:0] rx_meta_keep;
    logic                   rx_meta_vld;
    logic [META_TID_W-1:0]  rx_meta_tid;
    logic [META_TDT_W-1:0]  rx_meta_tdt;
    logic                   rx_meta_sop;
    logic                   rx_meta_eop;
    logic                   rx_meta_rdy;
    logic [META_DATA_W-1:0] tx_meta_data;
    logic [META_KEEP_W-1:0] tx_meta_keep;
    logic                   tx_meta_vld;
    logic [META_TID_W-1:0]  tx_meta_tid;
    logic [META_TDT_W-1:0]  tx_meta_tdt;
    logic                   tx_meta_sop;
    logic                   tx_meta_eop;
    logic                   tx_meta_rdy;

    axis_test dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_meta_data (rx_meta_data),
        .rx_meta_keep (rx_meta_keep),
        .rx_meta_vld  (rx_meta_vld),
        .rx_meta_tid  (rx_meta_tid),
        .rx_meta_tdt  (rx_meta_tdt),
        .rx_meta_sop  (rx_meta_sop),
        .rx_meta_eop  (rx_meta_eop),
        .rx_meta_rdy  (rx_meta_rdy),
        .tx_meta_data (tx_meta_data),
        .tx_meta_keep (tx_meta_keep),
        .tx_meta_vld  (tx_meta_vld),
        .tx_meta_tid  (tx_meta_tid),
        .tx_meta_tdt  (tx_meta_tdt),
        .tx_meta_sop  (tx_meta_sop),
        .tx_meta_eop  (tx_meta_eop),
        .tx_meta_rdy  (tx_meta_rdy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input chk_t act, input chk_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk_beat(input logic [META_DATA_W-1:0] d,
                                              input logic [META_KEEP_W-1:0] k,
                                              input logic [META_TID_W-1:0] id,
                                              input logic [META_TDT_W-1:0] dt,
                                              input logic s, input logic e);
        return {d, k, id, dt, s, e};
    endfunction

    task automatic drive_beat(input logic [META_DATA_W-1:0] d, input logic [META_KEEP_W-1:0] k,
                              input logic [META_TID_W-1:0] id, input logic [META_TDT_W-1:0] dt,
                              input logic s, input logic e);
        rx_meta_data = d;
        rx_meta_keep = k;
        rx_meta_tid  = id;
        rx_meta_tdt  = dt;
        rx_meta_sop  = s;
        rx_meta_eop  = e;
        rx_meta_vld  = 1'b1;
    endtask

    logic [BW-1:0] rx_beat;
    logic [BW-1:0] tx_beat;
    assign rx_beat = {rx_meta_data, rx_meta_keep, rx_meta_tid, rx_meta_tdt, rx_meta_sop, rx_meta_eop};
    assign tx_beat = {tx_meta_data, tx_meta_keep, tx_meta_tid, tx_meta_tdt, tx_meta_sop, tx_meta_eop};

    logic [BW-1:0] sb_q[$];
    logic [BW-1:0] out_q[$];
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_beat;

    // Pops are scored before this cycle's push is recorded: a push lands after the edge.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            sb_q.delete();
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("stall_vld", chk_t'(tx_meta_vld), chk_t'(1'b1));
                check_val("stall_dat", chk_t'(tx_beat), chk_t'(prev_beat));
            end
            if (tx_meta_vld && tx_meta_rdy) begin
                check_val("sb_nonempty", chk_t'(sb_q.size() != 0), chk_t'(1'b1));
                if (sb_q.size() != 0) begin
                    check_val("sb_beat", chk_t'(tx_beat), chk_t'(sb_q.pop_front()));
                end
                out_q.push_back(tx_beat);
            end
            if (rx_meta_vld && rx_meta_rdy) begin
                sb_q.push_back(rx_beat);
            end
            prev_stall <= tx_meta_vld && !tx_meta_rdy;
            prev_beat  <= tx_beat;
        end
    end

    task automatic drain(input int max_cyc);
        for (int c = 0; c < max_cyc; c++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check_val("drain_empty", chk_t'(sb_q.size()), chk_t'(0));
    endtask

    logic [BW-1:0] pkt_exp [4];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int cyc;
        logic took;

        rst_n        = 1'b0;
        rx_meta_vld  = 1'b0;
        rx_meta_data = '0;
        rx_meta_keep = '0;
        rx_meta_tid  = '0;
        rx_meta_tdt  = '0;
        rx_meta_sop  = 1'b0;
        rx_meta_eop  = 1'b0;
        tx_meta_rdy  = 1'b0;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_vld", chk_t'(tx_meta_vld), chk_t'(1'b0));
        check_val("rst_rdy", chk_t'(rx_meta_rdy), chk_t'(1'b1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rel_vld", chk_t'(tx_meta_vld), chk_t'(1'b0));
        check_val("rel_rdy", chk_t'(rx_meta_rdy), chk_t'(1'b1));

        // Single beat, one cycle latency.
        tx_meta_rdy = 1'b1;
        drive_beat(128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF, 4'd3, 4'd5, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        rx_meta_vld = 1'b0;
        check_val("single_lat", chk_t'(tx_meta_vld), chk_t'(1'b1));
        check_val("single_beat", chk_t'(tx_beat),
                  chk_t'(mk_beat(128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF, 4'd3, 4'd5, 1'b1, 1'b1)));
        check_val("single_tid", chk_t'(tx_meta_tid), chk_t'(4'd3));
        check_val("single_tdt", chk_t'(tx_meta_tdt), chk_t'(4'd5));
        @(posedge clk);
        #1;
        check_val("single_pop", chk_t'(tx_meta_vld), chk_t'(1'b0));

        // Four-beat packet, back to back.
        pkt_exp[0] = mk_beat(128'd0, 16'hFFFF, 4'd1, 4'd2, 1'b1, 1'b0);
        pkt_exp[1] = mk_beat(128'd1, 16'hFFFF, 4'd1, 4'd2, 1'b0, 1'b0);
        pkt_exp[2] = mk_beat(128'd2, 16'hFFFF, 4'd1, 4'd2, 1'b0, 1'b0);
        pkt_exp[3] = mk_beat(128'd3, 16'h00FF, 4'd1, 4'd2, 1'b0, 1'b1);
        out_q.delete();
        for (int i = 0; i < 4; i++) begin
            drive_beat(128'(i), (i == 3) ? 16'h00FF : 16'hFFFF, 4'd1, 4'd2, i == 0, i == 3);
            @(posedge clk);
            #1;
        end
        rx_meta_vld = 1'b0;
        @(posedge clk);
        #1;
        check_val("pkt_tput", chk_t'(out_q.size()), chk_t'(4));
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("pkt_beat%0d", i), chk_t'(out_q[i]), chk_t'(pkt_exp[i]));
        end

        // Fill to full with tx stalled, then drain.
        out_q.delete();
        tx_meta_rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_beat(128'(256 + i), 16'hFFFF, 4'(i), 4'(15 - i), i == 0, i == 15);
            @(posedge clk);
            #1;
        end
        check_val("full_rdy", chk_t'(rx_meta_rdy), chk_t'(1'b0));
        check_val("full_vld", chk_t'(tx_meta_vld), chk_t'(1'b1));
        check_val("full_head", chk_t'(tx_meta_data), chk_t'(128'h100));
        drive_beat(128'h1FF, 16'hFFFF, 4'd0, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_val("full_hold", chk_t'(rx_meta_rdy), chk_t'(1'b0));
        tx_meta_rdy = 1'b1;
        @(posedge clk);
        #1;
        check_val("rdy_after_pop", chk_t'(rx_meta_rdy), chk_t'(1'b1));
        rx_meta_vld = 1'b0;
        drain(64);
        check_val("fill_cnt", chk_t'(out_q.size()), chk_t'(16));
        for (int i = 0; i < 16; i++) begin
            check_val($sformatf("fill_dat%0d", i), chk_t'(out_q[i][BW-1 -: META_DATA_W]), chk_t'(256 + i));
        end

        // Random valid/ready over 1000 accepted beats.
        out_q.delete();
        acc = 0;
        cyc = 0;
        rx_meta_vld = 1'b0;
        while (acc < 1000 && cyc < 20000) begin
            @(negedge clk);
            took = rx_meta_vld && rx_meta_rdy;
            @(posedge clk);
            #1;
            cyc++;
            if (took) acc++;
            if (!rx_meta_vld || took) begin
                rx_meta_vld  = 1'($urandom_range(0, 1));
                rx_meta_data = {$urandom(), $urandom(), $urandom(), $urandom()};
                rx_meta_keep = 16'($urandom());
                rx_meta_tid  = 4'($urandom());
                rx_meta_tdt  = 4'($urandom());
                rx_meta_sop  = 1'($urandom_range(0, 1));
                rx_meta_eop  = 1'($urandom_range(0, 1));
            end
            tx_meta_rdy = 1'($urandom_range(0, 1));
        end
        rx_meta_vld = 1'b0;
        tx_meta_rdy = 1'b1;
        drain(64);
        check_val("rand_acc", chk_t'(acc), chk_t'(1000));
        check_val("rand_out", chk_t'(out_q.size()), chk_t'(1000));
        check_val("rand_idle", chk_t'(tx_meta_vld), chk_t'(1'b0));

        // Reset with five beats buffered.
        out_q.delete();
        tx_meta_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_beat(128'(512 + i), 16'hFFFF, 4'd7, 4'd7, i == 0, 1'b0);
            @(posedge clk);
            #1;
        end
        rx_meta_vld = 1'b0;
        check_val("pre_rst_vld", chk_t'(tx_meta_vld), chk_t'(1'b1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("mid_rst_vld", chk_t'(tx_meta_vld), chk_t'(1'b0));
        check_val("mid_rst_rdy", chk_t'(rx_meta_rdy), chk_t'(1'b1));
        drive_beat(128'h300, 16'h0F0F, 4'd9, 4'd10, 1'b1, 1'b1);
        tx_meta_rdy = 1'b1;
        @(posedge clk);
        #1;
        rx_meta_vld = 1'b0;
        drain(16);
        check_val("post_rst_cnt", chk_t'(out_q.size()), chk_t'(1));
        check_val("post_rst_beat", chk_t'(out_q[0]),
                  chk_t'(mk_beat(128'h300, 16'h0F0F, 4'd9, 4'd10, 1'b1, 1'b1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
